// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Loads a Y86-64 program image into the instruction memory write port
//   before execution. A byte stream arrives over a valid/ready handshake
//   and is framed as a 2-byte little-endian length, the payload bytes and
//   (optionally) a trailing XOR checksum byte. Each accepted payload byte
//   becomes one single-cycle memory write, issued one cycle after it was
//   accepted. The processor is held stalled until the image is complete
//   and verified.
//
// Configuration macro:
//   IMEM_LOADER_CHECKSUM_EN - when defined, a CHK state exists and a
//   trailing XOR checksum byte (over payload bytes only) is required.
//   When undefined, the last payload byte (or a zero length) goes
//   straight to DONE, and ERR is only reachable through the length check.
//
// Parameters:
//   ADDR_W    - instruction-memory byte-address width
//   DEPTH     - instruction-memory size in bytes (<= 2**ADDR_W)
//   BASE_ADDR - address of the first payload byte
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle pulse, begins a load from IDLE, DONE or ERR
//   i_in_valid     stream byte valid
//   i_in_data      stream byte
//   o_in_ready     loader accepts i_in_data this cycle
//   o_mem_wEn      instruction-memory write enable (one pulse per byte)
//   o_mem_addr     write byte address
//   o_mem_wdata    write byte
//   o_cpu_hold     processor stall/hold request
//   o_load_done    image loaded and verified
//   o_load_err     framing or checksum failure
//   o_byte_count   payload bytes written so far
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_wEn,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_byte_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Largest payload that still fits between BASE_ADDR and the top of memory.
  localparam logic [31:0] LIMIT = 32'(DEPTH - BASE_ADDR);

  state_t            r_state;
  state_t            w_nextState;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_byteCount;
  logic              r_wEn;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_cpuHold;
  logic              r_done;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_chk;
`endif

  logic              w_inReady;
  logic              w_xfer;
  logic [15:0]       w_lenFull;
  logic              w_lenTooBig;
  logic [ADDR_W:0]   w_cntNext;
  logic              w_lastByte;
  logic [ADDR_W:0]   w_addrFull;

  assign w_inReady   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                       (r_state == S_CHK) ||
`endif
                       (r_state == S_DATA);
  assign w_xfer      = i_in_valid & w_inReady;

  // Full length as it will look once the high byte is captured this cycle.
  assign w_lenFull   = {i_in_data, r_len[7:0]};
  assign w_lenTooBig = 32'(w_lenFull) > LIMIT;

  // The transfer that brings the count up to the length ends the payload.
  assign w_cntNext   = r_byteCount + (ADDR_W+1)'(1);
  assign w_lastByte  = (32'(w_cntNext) == 32'(r_len));

  // Address is formed one bit wider; the length check keeps it in range.
  assign w_addrFull  = (ADDR_W+1)'(BASE_ADDR) + r_byteCount;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; start is only honoured in the three resting states.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_nextState = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          w_nextState = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          if (w_lenTooBig) begin
            w_nextState = S_ERR;
          end else if (w_lenFull == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_nextState = S_CHK;
`else
            w_nextState = S_DONE;
`endif
          end else begin
            w_nextState = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer && w_lastByte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_nextState = S_CHK;
`else
          w_nextState = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) begin
          w_nextState = (i_in_data == r_chk) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: length capture, write pulse generation, counting and the
  // status flags, which follow the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len       <= '0;
      r_byteCount <= '0;
      r_wEn       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpuHold   <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_wEn     <= 1'b0;
      r_cpuHold <= (w_nextState != S_DONE);
      r_done    <= (w_nextState == S_DONE);
      r_err     <= (w_nextState == S_ERR);
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_byteCount <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk       <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= i_in_data;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= i_in_data;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_wEn       <= 1'b1;
            r_addr      <= w_addrFull[ADDR_W-1:0];
            r_wdata     <= i_in_data;
            r_byteCount <= w_cntNext;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk       <= r_chk ^ i_in_data;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_in_ready   = w_inReady;
  assign o_mem_wEn    = r_wEn;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_cpu_hold   = r_cpuHold;
  assign o_load_done  = r_done;
  assign o_load_err   = r_err;
  assign o_byte_count = r_byteCount;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Directed bench for imem_loader: framed byte streams with hand-computed
// expected writes, status flags and counts.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              inValid;
  logic [7:0]        inData;
  logic              inReady;
  logic              memWEn;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memWdata;
  logic              cpuHold;
  logic              loadDone;
  logic              loadErr;
  logic [ADDR_W:0]   byteCount;

  int compareCount = 0;
  int failCount    = 0;
  int cyc          = 0;
  int wAddr[$];
  int wData[$];
  int wCyc[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .BASE_ADDR(0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_in_valid   (inValid),
    .i_in_data    (inData),
    .o_in_ready   (inReady),
    .o_mem_wEn    (memWEn),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_cpu_hold   (cpuHold),
    .o_load_done  (loadDone),
    .o_load_err   (loadErr),
    .o_byte_count (byteCount)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp memory writes.
  always @(posedge clk) cyc++;

  // Log every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (memWEn === 1'b1) begin
      wAddr.push_back(int'(memAddr));
      wData.push_back(int'(memWdata));
      wCyc.push_back(cyc);
    end
  end

  function automatic int logA(int i);
    return (i < wAddr.size()) ? wAddr[i] : -1;
  endfunction

  function automatic int logD(int i);
    return (i < wData.size()) ? wData[i] : -1;
  endfunction

  function automatic int logGap(int i);
    return (i + 1 < wCyc.size()) ? (wCyc[i+1] - wCyc[i]) : -1;
  endfunction

  task automatic clearLog();
    wAddr.delete();
    wData.delete();
    wCyc.delete();
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    compareCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offer one byte and hold it until it has been transferred.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    inValid = 1'b1;
    inData  = b;
    while (inReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inData  = 8'h00;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_ready"}, int'(inReady), 0);
    checkOutput({pfx, "_wEn"}, int'(memWEn), 0);
    checkOutput({pfx, "_addr"}, int'(memAddr), 0);
    checkOutput({pfx, "_wdata"}, int'(memWdata), 0);
    checkOutput({pfx, "_hold"}, int'(cpuHold), 1);
    checkOutput({pfx, "_done"}, int'(loadDone), 0);
    checkOutput({pfx, "_err"}, int'(loadErr), 0);
    checkOutput({pfx, "_count"}, int'(byteCount), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;

    // Reset values while reset is held.
    #12;
    checkResetValues("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);

    // Basic 3-byte image, written back-to-back.
    clearLog();
    pulseStart();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h30);
    applyStimulus(8'hF2);
    applyStimulus(8'h0A);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(8'hC8);
`endif
    idleCycles(2);
    checkOutput("t1_nwr", wAddr.size(), 3);
    checkOutput("t1_a0", logA(0), 0);
    checkOutput("t1_a1", logA(1), 1);
    checkOutput("t1_a2", logA(2), 2);
    checkOutput("t1_d0", logD(0), 8'h30);
    checkOutput("t1_d1", logD(1), 8'hF2);
    checkOutput("t1_d2", logD(2), 8'h0A);
    checkOutput("t1_gap0", logGap(0), 1);
    checkOutput("t1_gap1", logGap(1), 1);
    checkOutput("t1_done", int'(loadDone), 1);
    checkOutput("t1_hold", int'(cpuHold), 0);
    checkOutput("t1_err", int'(loadErr), 0);
    checkOutput("t1_count", int'(byteCount), 3);
    checkOutput("t1_ready", int'(inReady), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum ends in ERR.
    pulseStart();
    checkOutput("t2_hold_start", int'(cpuHold), 1);
    checkOutput("t2_done_start", int'(loadDone), 0);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h30);
    applyStimulus(8'hF2);
    applyStimulus(8'h0A);
    applyStimulus(8'h00);
    idleCycles(1);
    checkOutput("t2_err", int'(loadErr), 1);
    checkOutput("t2_hold", int'(cpuHold), 1);
    checkOutput("t2_done", int'(loadDone), 0);
`endif

    // Reload a valid image from DONE (or ERR when the checksum is enabled).
    clearLog();
    pulseStart();
    checkOutput("t2r_hold_start", int'(cpuHold), 1);
    checkOutput("t2r_done_start", int'(loadDone), 0);
    checkOutput("t2r_err_start", int'(loadErr), 0);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(8'h33);
`endif
    idleCycles(2);
    checkOutput("t2r_done", int'(loadDone), 1);
    checkOutput("t2r_count", int'(byteCount), 2);
    checkOutput("t2r_a1", logA(1), 1);
    checkOutput("t2r_d1", logD(1), 8'h22);

    // Oversized length goes to ERR with no writes.
    clearLog();
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h04);
    checkOutput("t3_err", int'(loadErr), 1);
    checkOutput("t3_hold", int'(cpuHold), 1);
    checkOutput("t3_done", int'(loadDone), 0);
    checkOutput("t3_ready", int'(inReady), 0);
    idleCycles(3);
    checkOutput("t3_nwr", wAddr.size(), 0);

    // Start with a valid byte in a resting state: the byte is not taken.
    start   = 1'b1;
    inValid = 1'b1;
    inData  = 8'h55;
    #1;
    checkOutput("t4_ready_at_start", int'(inReady), 0);
    @(posedge clk);
    #1;
    start   = 1'b0;
    inValid = 1'b0;
    checkOutput("t4_err_cleared", int'(loadErr), 0);
    // Zero-length image.
    applyStimulus(8'h00);
    applyStimulus(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("t4_done_early", int'(loadDone), 0);
    checkOutput("t4_ready_chk", int'(inReady), 1);
    applyStimulus(8'h00);
`endif
    checkOutput("t4_done", int'(loadDone), 1);
    checkOutput("t4_hold", int'(cpuHold), 0);
    checkOutput("t4_count", int'(byteCount), 0);
    idleCycles(2);
    checkOutput("t4_nwr", wAddr.size(), 0);

    // Gapped valid; a stray start mid-payload must be ignored.
    clearLog();
    pulseStart();
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'hA1);
    idleCycles(1);
    applyStimulus(8'hB2);
    pulseStart();
    applyStimulus(8'hC3);
    idleCycles(1);
    applyStimulus(8'hD4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(8'h04);
`endif
    idleCycles(2);
    checkOutput("t5_nwr", wAddr.size(), 4);
    checkOutput("t5_a3", logA(3), 3);
    checkOutput("t5_d0", logD(0), 8'hA1);
    checkOutput("t5_d2", logD(2), 8'hC3);
    checkOutput("t5_d3", logD(3), 8'hD4);
    checkOutput("t5_gap0", logGap(0), 2);
    checkOutput("t5_gap1", logGap(1), 2);
    checkOutput("t5_gap2", logGap(2), 2);
    checkOutput("t5_count", int'(byteCount), 4);
    checkOutput("t5_done", int'(loadDone), 1);

    // Length equal to the whole memory is accepted; reset aborts mid-load.
    clearLog();
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h04);
    checkOutput("t6_err", int'(loadErr), 0);
    checkOutput("t6_ready", int'(inReady), 1);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    idleCycles(2);
    checkOutput("t6_count", int'(byteCount), 2);
    rst_n = 1'b0;
    #2;
    checkResetValues("t6rst");
    checkOutput("t6_nwr", wAddr.size(), 2);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("t6_idle_hold", int'(cpuHold), 1);
    checkOutput("t6_idle_ready", int'(inReady), 0);
    checkOutput("t6_nwr_after", wAddr.size(), 2);

    // Fresh load after reset starts again from address 0.
    clearLog();
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h5A);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(8'h5A);
`endif
    idleCycles(2);
    checkOutput("t7_nwr", wAddr.size(), 1);
    checkOutput("t7_a0", logA(0), 0);
    checkOutput("t7_d0", logD(0), 8'h5A);
    checkOutput("t7_done", int'(loadDone), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes a Y86-64 program image into the instruction memory's write port (wEn/address/data) before execution.
- Accepts a byte stream over a valid/ready handshake and frames it as: 2-byte little-endian length, payload bytes, then an optional XOR checksum byte.
- Emits one instruction-memory byte write per accepted payload byte.
- Holds the processor stalled until the image is complete and verified.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- DEPTH, 1024, instruction-memory size in bytes; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0, address of the first payload byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_wEn  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  write byte address.
- mem_wdata  out  8  write byte.
- cpu_hold  out  1  processor stall/hold request.
- load_done  out  1  image loaded and verified.
- load_err  out  1  framing or checksum failure.
- byte_count  out  ADDR_W+1  payload bytes written so far.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - state=IDLE, in_ready=0, mem_wEn=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0, byte_count=0.
  - Internal length=0, checksum accumulator=0.
- Reset mid-load aborts immediately. Partially written memory is left as is. No further writes are issued.
- A byte transfer happens only on a rising edge with in_valid & in_ready.
- in_ready=1 only in LEN_LO, LEN_HI, DATA and CHK. It is 0 in IDLE, DONE and ERR.
- State machine:
  - IDLE: start → LEN_LO. Also clears byte_count and checksum.
  - LEN_LO: transfer → length[7:0]=in_data; go to LEN_HI.
  - LEN_HI: transfer → length[15:8]=in_data.
    - If length > DEPTH-BASE_ADDR → ERR.
    - Else if length==0 → CHK (or DONE without the checksum macro).
    - Else → DATA.
  - DATA: each transfer registers a write.
    - Next cycle: mem_wEn=1, mem_addr=BASE_ADDR+byte_count (pre-increment value), mem_wdata=byte.
    - byte_count increments; checksum ^= byte.
    - The transfer that makes byte_count equal length → CHK (or DONE).
  - CHK: one transfer.
    - in_data==checksum → DONE.
    - Mismatch → ERR.
  - DONE: load_done=1, cpu_hold=0. start → LEN_LO with cpu_hold=1 and load_done=0, effective next cycle.
  - ERR: load_err=1, cpu_hold=1. start → LEN_LO and clears load_err.
- Write latency and throughput:
  - Write latency is exactly 1 cycle after transfer.
  - mem_wEn is a single-cycle pulse per byte.
  - Back-to-back transfers give consecutive-cycle writes at 1 byte/clk.
- Address arithmetic:
  - Computed in ADDR_W+1 bits.
  - Never wraps, because the length check in LEN_HI guarantees the last address is BASE_ADDR+length-1 ≤ DEPTH-1.
- start outside IDLE/DONE/ERR is ignored.
- start together with in_valid in IDLE: the byte is not accepted (in_ready=0 that cycle).
- Checksum covers payload bytes only, not length bytes. Initial value 0x00.
- cpu_hold is registered and changes on the same edge as the state change into or out of DONE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: the CHK state exists and a trailing checksum byte is required, as described above.
- Undefined:
  - No CHK state.
  - The final payload transfer (or LEN_HI with length==0) goes directly to DONE.
  - ERR is reachable only via the length check.

Test Plan:
- Reset, then start; stream 0x03,0x00,0x30,0xF2,0x0A,0xC8 (checksum 0x30^0xF2^0x0A=0xC8) → writes addr 0,1,2 = 0x30,0xF2,0x0A on consecutive cycles; then load_done=1, cpu_hold=0, byte_count=3.
- Same image but checksum byte 0x00 → load_err=1, cpu_hold=1, load_done=0. A following start plus valid image → DONE.
- Length 0x0401 (1025 > DEPTH) → ERR right after LEN_HI; no mem_wEn ever asserted.
- Length 0: stream 0x00,0x00,0x00 → DONE with zero writes. Without the macro, DONE right after the second byte.
- in_valid toggling 1,0,1,0 during DATA → writes only on transfer cycles; addresses contiguous; no duplicated writes.
- Assert rst=0 after 2 of 5 payload bytes → all outputs at reset values asynchronously. After release, IDLE with cpu_hold=1; a new start reloads from BASE_ADDR.
